// File: rtl/ga_pkg.sv
// Shared definitions for the genetic brew-run loop: sequencer state encoding
// and default sizing used by the generation controller, sorter and breeder.
package ga_pkg;

  localparam int DEF_POP_SIZE    = 50;   // sorter slots
  localparam int DEF_IDX_W       = 6;    // width of one sorted index
  localparam int DEF_GEN_W       = 10;   // generation counter width
  localparam int DEF_WDOG_CYCLES = 256;  // per-phase timeout in cycles

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVAL,
    ST_SORT,
    ST_BREED,
    ST_FINISH,
    ST_ERROR
  } ga_state_e;

  // True for the three states in which a sub-block is working.
  function automatic logic is_phase(input ga_state_e s);
    return (s == ST_EVAL) || (s == ST_SORT) || (s == ST_BREED);
  endfunction

endpackage

// File: rtl/ga_generation_ctrl_if.sv
// Start/done handshakes between the generation controller (master) and the
// fitness evaluator, population sorter and breeder (slave side).
interface ga_generation_ctrl_if
  import ga_pkg::*;
#(
  parameter int POP_SIZE = DEF_POP_SIZE,
  parameter int IDX_W    = DEF_IDX_W
) ();

  logic                      eval_start;
  logic                      eval_done;
  logic                      sort_start;
  logic                      sort_done;
  logic [POP_SIZE*IDX_W-1:0] sort_sorted;  // slot 0 in [IDX_W-1:0]
  logic                      breed_start;
  logic                      breed_done;

  modport master (
    output eval_start,
    input  eval_done,
    output sort_start,
    input  sort_done,
    input  sort_sorted,
    output breed_start,
    input  breed_done
  );

  modport slave (
    input  eval_start,
    output eval_done,
    input  sort_start,
    output sort_done,
    output sort_sorted,
    input  breed_start,
    output breed_done
  );

endinterface

// File: rtl/ga_phase_watchdog.sv
// Per-phase timeout counter. Cleared on every phase entry, counts while the
// controller is in a phase, and flags the WDOG_CYCLES-th cycle of that phase.
module ga_phase_watchdog
  import ga_pkg::*;
#(
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WDOG_CYCLES - 1);

  logic [CNT_W-1:0] count_q;

  // Cycles spent in the current phase; saturates on the terminal cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != LAST)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Entry cycle is count 0, so LAST marks the WDOG_CYCLES-th cycle in phase.
  assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/ga_generation_ctrl.sv
// Generation sequencer: runs evaluate -> sort -> breed for a programmed number
// of generations, latching the fittest index after each sort.
// Optional feature: define GA_PHASE_WATCHDOG_EN to enable the per-phase
// timeout and the ERROR state; otherwise phases wait indefinitely.
module ga_generation_ctrl
  import ga_pkg::*;
#(
  parameter int POP_SIZE    = DEF_POP_SIZE,
  parameter int IDX_W       = DEF_IDX_W,
  parameter int GEN_W       = DEF_GEN_W,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 abort,
  input  logic [GEN_W-1:0]     num_generations,
  ga_generation_ctrl_if.master phase_if,
  output logic                 busy,
  output logic [GEN_W-1:0]     gen_count,
  output logic [IDX_W-1:0]     best_index,
  output logic                 done,
  output logic                 error
);

  ga_state_e        state_q, state_d;
  logic [GEN_W-1:0] n_q, n_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic [GEN_W-1:0] gen_inc;
  logic [IDX_W-1:0] best_q, best_d;
  logic             err_q, err_d;
  logic             eval_start_q, eval_start_d;
  logic             sort_start_q, sort_start_d;
  logic             breed_start_q, breed_start_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             wdog_expired;

  // Only slot 0 of the sorted population matters to the sequencer.
  logic unused_sorted_hi;
  assign unused_sorted_hi = ^phase_if.sort_sorted[POP_SIZE*IDX_W-1:IDX_W];

`ifdef GA_PHASE_WATCHDOG_EN
  logic wdog_clear;
  assign wdog_clear = (state_d != state_q);

  ga_phase_watchdog #(
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wdog_clear),
    .enable  (is_phase(state_q)),
    .expired (wdog_expired)
  );
`else
  localparam int unused_wdog_cycles = WDOG_CYCLES;
  assign wdog_expired = 1'b0;
`endif

  // Next-state and next-output decode; abort is checked before any done input.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned -- an unassigned path in always_comb infers a latch.
    state_d       = state_q;
    n_d           = n_q;
    gen_d         = gen_q;
    best_d        = best_q;
    err_d         = err_q;
    eval_start_d  = 1'b0;
    sort_start_d  = 1'b0;
    breed_start_d = 1'b0;
    done_d        = 1'b0;
    gen_inc       = gen_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (run) begin
          if (num_generations != '0) begin
            n_d          = num_generations;
            gen_d        = '0;
            err_d        = 1'b0;
            eval_start_d = 1'b1;
            state_d      = ST_EVAL;
          end else begin
            done_d  = 1'b1;
            state_d = ST_FINISH;
          end
        end
      end
      ST_EVAL: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (phase_if.eval_done) begin
          sort_start_d = 1'b1;
          state_d      = ST_SORT;
        end else if (wdog_expired) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end
      end
      ST_SORT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (phase_if.sort_done) begin
          best_d        = phase_if.sort_sorted[IDX_W-1:0];
          breed_start_d = 1'b1;
          state_d       = ST_BREED;
        end else if (wdog_expired) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end
      end
      ST_BREED: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (phase_if.breed_done) begin
          gen_d = gen_inc;
          if (gen_inc == n_q) begin
            done_d  = 1'b1;
            state_d = ST_FINISH;
          end else begin
            eval_start_d = 1'b1;
            state_d      = ST_EVAL;
          end
        end else if (wdog_expired) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end
      end
      ST_FINISH, ST_ERROR: begin
        // Parked until the run request is withdrawn.
        if (abort || !run) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = is_phase(state_d);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      n_q           <= '0;
      gen_q         <= '0;
      best_q        <= '0;
      err_q         <= 1'b0;
      eval_start_q  <= 1'b0;
      sort_start_q  <= 1'b0;
      breed_start_q <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order within and across blocks.
      state_q       <= state_d;
      n_q           <= n_d;
      gen_q         <= gen_d;
      best_q        <= best_d;
      err_q         <= err_d;
      eval_start_q  <= eval_start_d;
      sort_start_q  <= sort_start_d;
      breed_start_q <= breed_start_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
    end
  end

  assign phase_if.eval_start  = eval_start_q;
  assign phase_if.sort_start  = sort_start_q;
  assign phase_if.breed_start = breed_start_q;
  assign busy                 = busy_q;
  assign gen_count            = gen_q;
  assign best_index           = best_q;
  assign done                 = done_q;
  assign error                = err_q;

endmodule

// File: tb/tb_ga_generation_ctrl.sv
// Bench for ga_generation_ctrl: directed runs with auto-responding sub-blocks,
// a per-cycle comparison against a behavioural sequencer model, and literal
// expectations for the headline timings and values.
module tb_ga_generation_ctrl;
  import ga_pkg::*;

  localparam int POP_SIZE = 50;
  localparam int IDX_W    = 6;
  localparam int GEN_W    = 10;
  localparam int WDOG     = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             run;
  logic             abort;
  logic [GEN_W-1:0] num_generations;
  logic             busy;
  logic [GEN_W-1:0] gen_count;
  logic [IDX_W-1:0] best_index;
  logic             done;
  logic             error;

  ga_generation_ctrl_if #(.POP_SIZE(POP_SIZE), .IDX_W(IDX_W)) phase_if ();

  ga_generation_ctrl #(
    .POP_SIZE    (POP_SIZE),
    .IDX_W       (IDX_W),
    .GEN_W       (GEN_W),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .run             (run),
    .abort           (abort),
    .num_generations (num_generations),
    .phase_if        (phase_if),
    .busy            (busy),
    .gen_count       (gen_count),
    .best_index      (best_index),
    .done            (done),
    .error           (error)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit eval_hold  = 1'b0;
  bit sort_hold  = 1'b0;
  bit breed_hold = 1'b0;
  int slot0_q[$];
  int n_eval, n_sort, n_breed;
  bit busy_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Sub-block stand-ins: answer a start in the same cycle it is visible.
  initial begin
    logic [POP_SIZE*IDX_W-1:0] v;
    phase_if.eval_done   = 1'b0;
    phase_if.sort_done   = 1'b0;
    phase_if.breed_done  = 1'b0;
    phase_if.sort_sorted = '0;
    forever begin
      @(negedge clk);
      phase_if.eval_done  = phase_if.eval_start && !eval_hold;
      phase_if.breed_done = phase_if.breed_start && !breed_hold;
      phase_if.sort_done  = 1'b0;
      if (phase_if.sort_start && !sort_hold) begin
        for (int s = 0; s < POP_SIZE; s++) v[s*IDX_W +: IDX_W] = IDX_W'($urandom_range(0, POP_SIZE-1));
        if (slot0_q.size() > 0) v[IDX_W-1:0] = IDX_W'(slot0_q.pop_front());
        phase_if.sort_sorted = v;
        phase_if.sort_done   = 1'b1;
      end
    end
  end

  // Behavioural model: a run is "active" in one of three phases (0 eval,
  // 1 sort, 2 breed) or "parked" after finishing/erroring until run drops.
  bit               m_active, m_parked, m_err;
  int               m_phase, m_gen, m_n, m_tip;
  logic [IDX_W-1:0] m_best;
  bit               e_eval, e_sort, e_breed, e_done;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_active = 0; m_parked = 0; m_err = 0; m_phase = 0; m_gen = 0; m_n = 0;
      m_tip = 0; m_best = '0; e_eval = 0; e_sort = 0; e_breed = 0; e_done = 0;
    end else begin
      e_eval = 0; e_sort = 0; e_breed = 0; e_done = 0;
      if (m_active) begin
        bit fin;
        m_tip++;
        fin = (m_phase == 0) ? phase_if.eval_done :
              (m_phase == 1) ? phase_if.sort_done : phase_if.breed_done;
        if (abort) begin
          m_active = 0;
        end else if (fin) begin
          m_tip = 0;
          if (m_phase == 0) begin
            m_phase = 1; e_sort = 1;
          end else if (m_phase == 1) begin
            m_best = phase_if.sort_sorted[IDX_W-1:0]; m_phase = 2; e_breed = 1;
          end else begin
            m_gen++;
            if (m_gen == m_n) begin
              m_active = 0; m_parked = 1; e_done = 1;
            end else begin
              m_phase = 0; e_eval = 1;
            end
          end
`ifdef GA_PHASE_WATCHDOG_EN
        end else if (m_tip >= WDOG) begin
          m_active = 0; m_parked = 1; m_err = 1;
`endif
        end
      end else if (m_parked) begin
        if (!run || abort) m_parked = 0;
      end else if (run) begin
        if (num_generations != 0) begin
          m_n = int'(num_generations); m_gen = 0; m_err = 0; m_active = 1;
          m_phase = 0; m_tip = 0; e_eval = 1;
        end else begin
          m_parked = 1; e_done = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus pulse bookkeeping.
  initial forever begin
    @(negedge clk);
    check("busy",        busy,                 32'(m_active));
    check("gen_count",   gen_count,            32'(m_gen));
    check("best_index",  best_index,           32'(m_best));
    check("done",        done,                 32'(e_done));
    check("error",       error,                32'(m_err));
    check("eval_start",  phase_if.eval_start,  32'(e_eval));
    check("sort_start",  phase_if.sort_start,  32'(e_sort));
    check("breed_start", phase_if.breed_start, 32'(e_breed));
    if (phase_if.eval_start)  n_eval++;
    if (phase_if.sort_start)  n_sort++;
    if (phase_if.breed_start) n_breed++;
    if (busy) busy_seen = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic clear_counts();
    n_eval = 0; n_sort = 0; n_breed = 0; busy_seen = 1'b0;
  endtask

  // Wait (bounded) for the done pulse, flagging a timeout as a failure.
  task automatic wait_done(input string name, input int bound);
    bit got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) check(name, 0, 1);
  endtask

  initial begin
    int t0;
    bit got, c1, c2;
    rst_n = 1'b0; run = 1'b0; abort = 1'b0; num_generations = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_gen", gen_count, 0);
    check("rst_best", best_index, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    @(negedge clk);

    // N=3 at minimum phase latency; slot 0 = 17, 4, 9.
    clear_counts();
    slot0_q = '{17, 4, 9};
    num_generations = 3; run = 1'b1; t0 = cyc;
    got = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (gen_count == 1 && !c1) begin check("best_gen1", best_index, 17); c1 = 1; end
      if (gen_count == 2 && !c2) begin check("best_gen2", best_index, 4); c2 = 1; end
      if (done) begin got = 1; check("done_cycle", cyc - t0, 10); end
    end
    if (!got) check("n3_done_timeout", 0, 1);
    check("n3_gen_count", gen_count, 3);
    check("n3_eval_pulses", n_eval, 3);
    check("n3_sort_pulses", n_sort, 3);
    check("n3_breed_pulses", n_breed, 3);
    repeat (3) @(negedge clk);
    check("finish_no_restart", n_eval, 3);
    run = 1'b0;
    repeat (2) @(negedge clk);

    // N=0: immediate done, nothing started.
    clear_counts();
    num_generations = 0; run = 1'b1;
    @(negedge clk);
    check("zero_done", done, 1);
    @(negedge clk);
    check("zero_done_once", done, 0);
    check("zero_no_eval", n_eval, 0);
    check("zero_busy_seen", busy_seen, 0);
    run = 1'b0;
    repeat (2) @(negedge clk);

    // Abort together with sort_done in generation 2.
    clear_counts();
    slot0_q = '{17, 23};
    num_generations = 3; run = 1'b1;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (phase_if.sort_start && gen_count == 1) begin
        abort = 1'b1; run = 1'b0; got = 1;
      end
    end
    if (!got) check("abort_setup_timeout", 0, 1);
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_no_breed", phase_if.breed_start, 0);
    check("abort_gen", gen_count, 1);
    check("abort_best", best_index, 17);
    check("abort_breed_pulses", n_breed, 1);
    repeat (2) @(negedge clk);
    slot0_q.delete();

`ifdef GA_PHASE_WATCHDOG_EN
    // Breeder never answers: ERROR after WDOG cycles in BREED.
    breed_hold = 1'b1;
    num_generations = 2; run = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (phase_if.breed_start) begin got = 1; t0 = cyc; end
    end
    if (!got) check("wdog_breed_timeout", 0, 1);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (error) begin got = 1; check("wdog_latency", cyc - t0, WDOG); end
    end
    if (!got) check("wdog_error_timeout", 0, 1);
    check("wdog_busy", busy, 0);
    run = 1'b0; breed_hold = 1'b0;
    repeat (2) @(negedge clk);
    check("wdog_error_sticky", error, 1);
    num_generations = 1; run = 1'b1;
    @(negedge clk);
    check("wdog_error_cleared", error, 0);
    check("wdog_restart_eval", phase_if.eval_start, 1);
    wait_done("wdog_rerun_done_timeout", 20);
    run = 1'b0;
    repeat (2) @(negedge clk);
`endif

    // Reset while the sorter is busy in generation 2.
    slot0_q = '{33};
    num_generations = 2; run = 1'b1;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (phase_if.breed_start && gen_count == 0) sort_hold = 1'b1;
      if (phase_if.sort_start && gen_count == 1) got = 1;
    end
    if (!got) check("rst_setup_timeout", 0, 1);
    check("rst_pre_best", best_index, 33);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_gen", gen_count, 0);
    check("midrst_best", best_index, 0);
    check("midrst_sort_start", phase_if.sort_start, 0);
    check("midrst_error", error, 0);
    sort_hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("fresh_eval", phase_if.eval_start, 1);
    check("fresh_gen", gen_count, 0);
    check("fresh_busy", busy, 1);
    wait_done("fresh_done_timeout", 30);
    check("fresh_gen_final", gen_count, 2);
    run = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
